// File: rtl/enemy_hit_tracker.sv
// Per-frame collision, lifeforce and score manager for N enemy ships and the player.
// Overlaps are latched during the scan and committed once per frame on i_animate.
module enemy_hit_tracker #(
  parameter int N_ENEMY        = 4,
  parameter int RESPAWN_FRAMES = 120,
  parameter int LIVES          = 3,
  parameter int INVULN_FRAMES  = 60,
  parameter int POINTS         = 10,
  parameter int SCORE_W        = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_pix_stb,
  input  logic               i_animate,
  input  logic               i_paused,
  input  logic               i_pbullet,
  input  logic               i_player_px,
  input  logic               i_ebullet,
  input  logic [N_ENEMY-1:0] i_enemy_px,
  output logic [N_ENEMY-1:0] o_alive,
  output logic               o_bullet_kill,
  output logic               o_player_hit,
  output logic [2:0]         o_lives,
  output logic [SCORE_W-1:0] o_score,
  output logic               o_game_over
);

  typedef enum logic {ST_PLAY, ST_GAME_OVER} state_t;

  localparam logic [7:0]         RESP_INIT   = 8'(RESPAWN_FRAMES);
  localparam logic [7:0]         INVULN_INIT = 8'(INVULN_FRAMES);
  localparam logic [2:0]         LIVES_INIT  = 3'(LIVES);
  localparam int                 SUM_W       = SCORE_W + 33;
  localparam logic [SCORE_W-1:0] SCORE_MAX   = {SCORE_W{1'b1}};

  state_t               state_reg, state_next;
  logic [N_ENEMY-1:0]   pend_e_reg, pend_e_next;
  logic [N_ENEMY-1:0]   alive_reg, alive_next;
  logic [7:0]           resp_reg  [N_ENEMY];
  logic [7:0]           resp_next [N_ENEMY];
  logic                 pend_p_reg, pend_p_next;
  logic [7:0]           invuln_reg, invuln_next;
  logic [2:0]           lives_reg, lives_next;
  logic [SCORE_W-1:0]   score_reg, score_next;
  logic                 kill_reg, kill_next;

  logic                 sample_en;
  logic                 commit_en;
  logic [4:0]           hit_cnt;
  logic [31:0]          add_pts;
  logic [SUM_W-1:0]     score_sum;

  // A sample coincident with the frame strobe is dropped; the strobe always clears pending flags.
  assign sample_en = (state_reg == ST_PLAY) & i_pix_stb & ~i_animate;
  assign commit_en = i_animate & (state_reg == ST_PLAY) & ~i_paused;

  genvar gi;
  generate
    for (gi = 0; gi < N_ENEMY; gi++) begin : g_enemy
      assign pend_e_next[gi] = i_animate ? 1'b0
                             : (pend_e_reg[gi] | (sample_en & i_pbullet & i_enemy_px[gi] & alive_reg[gi]));

      always_comb begin
        alive_next[gi] = alive_reg[gi];
        resp_next[gi]  = resp_reg[gi];
        if (commit_en) begin
          if (pend_e_reg[gi]) begin
            alive_next[gi] = 1'b0;
            resp_next[gi]  = RESP_INIT;
          end else if (!alive_reg[gi] && resp_reg[gi] != 8'd0) begin
            resp_next[gi] = resp_reg[gi] - 8'd1;
            if (resp_reg[gi] == 8'd1) alive_next[gi] = 1'b1;
          end
        end
      end
    end
  endgenerate

  always_comb begin
    hit_cnt = 5'd0;
    for (int k = 0; k < N_ENEMY; k++) hit_cnt = hit_cnt + 5'(pend_e_reg[k]);
  end

  assign add_pts   = 32'(POINTS) * 32'(hit_cnt);
  assign score_sum = SUM_W'(score_reg) + SUM_W'(add_pts);

  always_comb begin
    state_next  = state_reg;
    score_next  = score_reg;
    lives_next  = lives_reg;
    invuln_next = invuln_reg;
    kill_next   = 1'b0;
    pend_p_next = pend_p_reg;

    if (i_animate)
      pend_p_next = 1'b0;
    else if (sample_en && i_ebullet && i_player_px && invuln_reg == 8'd0)
      pend_p_next = 1'b1;

    if (commit_en) begin
      kill_next  = |pend_e_reg;
      score_next = (score_sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : score_sum[SCORE_W-1:0];
      if (pend_p_reg) begin
        lives_next  = (lives_reg == 3'd0) ? 3'd0 : lives_reg - 3'd1;
        invuln_next = INVULN_INIT;
        if (lives_reg <= 3'd1) state_next = ST_GAME_OVER;
      end else if (invuln_reg != 8'd0) begin
        invuln_next = invuln_reg - 8'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg  <= ST_PLAY;
      pend_e_reg <= '0;
      alive_reg  <= '1;
      pend_p_reg <= 1'b0;
      invuln_reg <= 8'd0;
      lives_reg  <= LIVES_INIT;
      score_reg  <= '0;
      kill_reg   <= 1'b0;
      for (int k = 0; k < N_ENEMY; k++) resp_reg[k] <= 8'd0;
    end else begin
      state_reg  <= state_next;
      pend_e_reg <= pend_e_next;
      alive_reg  <= alive_next;
      pend_p_reg <= pend_p_next;
      invuln_reg <= invuln_next;
      lives_reg  <= lives_next;
      score_reg  <= score_next;
      kill_reg   <= kill_next;
      for (int k = 0; k < N_ENEMY; k++) resp_reg[k] <= resp_next[k];
    end
  end

  assign o_alive       = alive_reg;
  assign o_bullet_kill = kill_reg;
  assign o_player_hit  = (invuln_reg != 8'd0);
  assign o_lives       = lives_reg;
  assign o_score       = score_reg;
  assign o_game_over   = (state_reg == ST_GAME_OVER);

endmodule

// File: tb/tb_enemy_hit_tracker.sv
// Bench for enemy_hit_tracker: directed scenarios plus randomized frames against a frame-level model.
// A second instance with a 5-bit score shares all inputs to exercise saturation.
module tb_enemy_hit_tracker;

  localparam int NE   = 4;
  localparam int RESP = 120;
  localparam int LIV  = 3;
  localparam int INV  = 60;
  localparam int PTS  = 10;

  logic clk = 1'b0;
  logic rst_n, pix_stb, animate, paused, pbullet, player_px, ebullet;
  logic [NE-1:0] enemy_px;

  logic [NE-1:0] alive_a, alive_b;
  logic          kill_a, kill_b, phit_a, phit_b, over_a, over_b;
  logic [2:0]    lives_a, lives_b;
  logic [15:0]   score_a;
  logic [4:0]    score_b;

  int n_tests = 0;
  int n_fail  = 0;

  // model state (frame-level view of the game)
  bit m_alive[NE];
  int m_dead[NE];
  bit m_hit_e[NE];
  bit m_hit_p;
  int m_score, m_lives, m_inv;
  bit m_over, m_kill;

  always #5 clk = ~clk;

  enemy_hit_tracker #(.N_ENEMY(NE), .RESPAWN_FRAMES(RESP), .LIVES(LIV),
                      .INVULN_FRAMES(INV), .POINTS(PTS), .SCORE_W(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_stb(pix_stb), .i_animate(animate),
    .i_paused(paused), .i_pbullet(pbullet), .i_player_px(player_px),
    .i_ebullet(ebullet), .i_enemy_px(enemy_px), .o_alive(alive_a),
    .o_bullet_kill(kill_a), .o_player_hit(phit_a), .o_lives(lives_a),
    .o_score(score_a), .o_game_over(over_a));

  enemy_hit_tracker #(.N_ENEMY(NE), .RESPAWN_FRAMES(RESP), .LIVES(LIV),
                      .INVULN_FRAMES(INV), .POINTS(PTS), .SCORE_W(5)) dut_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_stb(pix_stb), .i_animate(animate),
    .i_paused(paused), .i_pbullet(pbullet), .i_player_px(player_px),
    .i_ebullet(ebullet), .i_enemy_px(enemy_px), .o_alive(alive_b),
    .o_bullet_kill(kill_b), .o_player_hit(phit_b), .o_lives(lives_b),
    .o_score(score_b), .o_game_over(over_b));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NE-1:0] model_alive();
    logic [NE-1:0] v;
    for (int k = 0; k < NE; k++) v[k] = m_alive[k];
    return v;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < NE; k++) begin
      m_alive[k] = 1'b1; m_dead[k] = 0; m_hit_e[k] = 1'b0;
    end
    m_hit_p = 1'b0; m_score = 0; m_lives = LIV; m_inv = 0; m_over = 1'b0; m_kill = 1'b0;
  endfunction

  function automatic void model_commit();
    int n = 0;
    for (int k = 0; k < NE; k++) begin
      if (m_hit_e[k]) begin
        m_alive[k] = 1'b0; m_dead[k] = RESP; n++;
      end else if (!m_alive[k]) begin
        m_dead[k]--;
        if (m_dead[k] == 0) m_alive[k] = 1'b1;
      end
    end
    m_score += PTS * n;
    m_kill = (n > 0);
    if (m_hit_p) begin
      if (m_lives > 0) m_lives--;
      m_inv = INV;
      if (m_lives == 0) m_over = 1'b1;
    end else if (m_inv > 0) begin
      m_inv--;
    end
  endfunction

  task automatic compare_all();
    int s16 = (m_score > 65535) ? 65535 : m_score;
    int s5  = (m_score > 31) ? 31 : m_score;
    check("alive",      alive_a, model_alive());
    check("score",      score_a, s16);
    check("lives",      lives_a, m_lives);
    check("game_over",  over_a,  m_over);
    check("bullet_kill", kill_a, m_kill);
    check("player_hit", phit_a,  m_inv != 0);
    check("sat_score",  score_b, s5);
    check("sat_alive",  alive_b, model_alive());
    check("sat_misc",   {kill_b, phit_b, over_b, lives_b}, {m_kill, m_inv != 0, m_over, 3'(m_lives)});
  endtask

  // One clock: drive inputs, advance model at the edge, compare 1ns later.
  task automatic step(input bit r, input bit stb, input bit anim, input bit pau,
                      input bit pb, input bit pp, input bit eb, input logic [NE-1:0] epx);
    rst_n = r; pix_stb = stb; animate = anim; paused = pau;
    pbullet = pb; player_px = pp; ebullet = eb; enemy_px = epx;
    @(posedge clk);
    if (!r) begin
      model_reset();
    end else begin
      m_kill = 1'b0;
      if (anim) begin
        if (!m_over && !pau) model_commit();
        for (int k = 0; k < NE; k++) m_hit_e[k] = 1'b0;
        m_hit_p = 1'b0;
      end else if (stb && !m_over) begin
        for (int k = 0; k < NE; k++)
          if (pb && epx[k] && m_alive[k]) m_hit_e[k] = 1'b1;
        if (eb && pp && m_inv == 0) m_hit_p = 1'b1;
      end
    end
    #1;
    compare_all();
    if (r && anim)
      $display("[TB] commit paused=%0d alive=%b score=%0d lives=%0d over=%0d",
               pau, alive_a, score_a, lives_a, over_a);
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0, 0, '0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, '0);
  endtask

  // n overlap pixels with the given sources, then an animate
  task automatic frame(input int n, input bit pb, input bit pp, input bit eb,
                       input logic [NE-1:0] epx, input bit pau);
    for (int i = 0; i < n; i++) step(1, 1, 0, 0, pb, pp, eb, epx);
    step(1, 0, 1, pau, 0, 0, 0, '0);
  endtask

  initial begin
    rst_n = 1'b0; pix_stb = 0; animate = 0; paused = 0;
    pbullet = 0; player_px = 0; ebullet = 0; enemy_px = '0;
    model_reset();

    // T1 reset
    do_reset(2);
    check("t1_alive", alive_a, 4'b1111);
    check("t1_score", score_a, 0);
    check("t1_lives", lives_a, 3);
    check("t1_over",  over_a,  0);

    // T2 single enemy hit over 5 pixels
    idle();
    frame(5, 1, 0, 0, 4'b0100, 0);
    check("t2_alive", alive_a, 4'b1011);
    check("t2_score", score_a, 10);
    check("t2_kill",  kill_a,  1);
    idle();
    check("t2_kill_end", kill_a, 0);

    // T3 respawn after 120 unpaused frames; paused frames do not count
    for (int f = 0; f < 119; f++) begin
      if (f % 10 == 3) frame(2, 1, 0, 0, 4'b0100, 1);
      frame(1, 0, 0, 0, '0, 0);
    end
    check("t3_still_dead", alive_a[2], 0);
    frame(1, 0, 0, 0, '0, 0);
    check("t3_respawn", alive_a, 4'b1111);

    // T4 two enemies in one frame, then saturation of the 5-bit instance
    frame(3, 1, 0, 0, 4'b1001, 0);
    check("t4_score", score_a, 30);
    check("t4_alive", alive_a, 4'b0110);
    frame(2, 1, 0, 0, 4'b0010, 0);
    check("t4_score40", score_a, 40);
    check("t4_sat",     score_b, 31);

    // T5 lives and invulnerability
    frame(2, 0, 1, 1, '0, 0);
    check("t5_lives2", lives_a, 2);
    check("t5_phit",   phit_a,  1);
    for (int f = 0; f < INV; f++) frame(2, 0, 1, 1, '0, 0);
    check("t5_invuln_lives", lives_a, 2);
    check("t5_invuln_end",   phit_a,  0);
    frame(1, 0, 1, 1, '0, 0);
    check("t5_lives1", lives_a, 1);
    for (int f = 0; f < INV; f++) frame(1, 0, 0, 0, '0, 0);
    frame(1, 0, 1, 1, '0, 0);
    check("t5_lives0", lives_a, 0);
    check("t5_over",   over_a,  1);
    frame(2, 1, 1, 1, 4'b1111, 0);
    check("t5_frozen_lives", lives_a, 0);
    check("t5_frozen_kill",  kill_a,  0);

    // T6 reset mid-frame discards a pending enemy hit
    do_reset(1);
    step(1, 1, 0, 0, 1, 0, 0, 4'b0010);
    do_reset(1);
    step(1, 0, 1, 0, 0, 0, 0, '0);
    check("t6_alive", alive_a, 4'b1111);
    check("t6_score", score_a, 0);
    check("t6_kill",  kill_a,  0);

    // randomized episodes
    for (int ep = 0; ep < 6; ep++) begin
      do_reset(1);
      for (int f = 0; f < 100; f++) begin
        int len = $urandom_range(24, 4);
        for (int c = 0; c < len; c++) begin
          bit r   = ($urandom % 400) != 0;
          bit stb = ($urandom % 3) == 0;
          bit pb  = ($urandom % 3) == 0;
          bit hp  = ($urandom % 25) == 0;
          logic [NE-1:0] epx = NE'($urandom);
          step(r, stb, 0, 0, pb, hp | (($urandom % 2) == 0), hp, epx);
        end
        begin
          bit pau = ($urandom % 5) == 0;
          step(1, $urandom % 2, 1, pau, $urandom % 2, $urandom % 2, $urandom % 2, NE'($urandom));
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
